imem_boot_loader: RTL and testbench

- Upstream of the single-cycle RISC-V core.
- Receives a framed byte stream (e.g. from a UART RX) and assembles little-endian 32-bit instruction words.
- Writes those words into the instruction memory's write port.
- Holds the core in reset until a load completes with a valid checksum.

---
 rtl/imem_boot_loader_pkg.sv | 29 ++
 rtl/imem_boot_loader_word_assembler.sv | 65 ++++++
 rtl/imem_boot_loader.sv | 188 ++++++++++++++++++
 tb/tb_imem_boot_loader.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader:
// FSM state encoding, default frame marker and checksum helpers.
package imem_boot_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN0  = 3'd1,
        ST_LEN1  = 3'd2,
        ST_DATA  = 3'd3,
        ST_CSUM  = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERROR = 3'd6
    } boot_state_e;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         CSUM_WIDTH        = 8;

    function automatic logic [CSUM_WIDTH-1:0] csum_update(
        input logic [CSUM_WIDTH-1:0] acc,
        input logic [7:0]            data
    );
        return acc ^ data;
    endfunction

    function automatic logic state_is_busy(input boot_state_e s);
        return (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_DATA) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/imem_boot_loader_word_assembler.sv
// Collects four bytes (LSB first) into a 32-bit word and emits a registered
// one-cycle word_valid pulse together with the completed word.
module boot_word_assembler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic        byte_en_i,
    input  logic [7:0]  byte_i,
    output logic        last_byte_o,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [1:0]  idx_q,   idx_d;
    logic [23:0] lanes_q, lanes_d;
    logic        valid_q, valid_d;
    logic [31:0] word_q,  word_d;

    // Lane steering and byte index; the top byte completes the word directly.
    always_comb begin
        idx_d   = idx_q;
        lanes_d = lanes_q;
        word_d  = word_q;
        valid_d = 1'b0;
        if (clear_i) begin
            idx_d   = 2'd0;
            lanes_d = 24'd0;
        end else if (byte_en_i) begin
            idx_d = idx_q + 2'd1;
            case (idx_q)
                2'd0: lanes_d[7:0]   = byte_i;
                2'd1: lanes_d[15:8]  = byte_i;
                2'd2: lanes_d[23:16] = byte_i;
                2'd3: begin
                    word_d  = {byte_i, lanes_q};
                    valid_d = 1'b1;
                    lanes_d = 24'd0;
                end
                default: lanes_d = 24'd0;
            endcase
        end else begin
            idx_d = idx_q;
        end
    end

    // Assembler state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= 2'd0;
            lanes_q <= 24'd0;
            valid_q <= 1'b0;
            word_q  <= 32'd0;
        end else begin
            idx_q   <= idx_d;
            lanes_q <= lanes_d;
            valid_q <= valid_d;
            word_q  <= word_d;
        end
    end

    assign last_byte_o  = byte_en_i && !clear_i && (idx_q == 2'd3);
    assign word_valid_o = valid_q;
    assign word_o       = word_q;

endmodule

// File: rtl/imem_boot_loader.sv
// Framed byte-stream boot loader: parses SYNC/LEN/DATA/CSUM frames, writes
// words into IMEM and releases the core reset once the checksum matches.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int         ADDR_WIDTH = 10,
    parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_waddr,
    output logic [31:0]           imem_wdata,
    output logic                  core_rst_n,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [15:0]           words_loaded
);

    localparam logic [16:0] IMEM_WORDS = 17'(2 ** ADDR_WIDTH);

    boot_state_e             state_q, state_d;
    logic [7:0]              len_lo_q, len_lo_d;
    logic [15:0]             len_q, len_d;
    logic [15:0]             words_q, words_d;
    logic [CSUM_WIDTH-1:0]   acc_q, acc_d;
    logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
    logic                    core_rst_n_q, core_rst_n_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;

    logic                    in_ready_s;
    logic                    accept_s;
    logic                    sync_s;
    logic                    asm_clear_s;
    logic                    asm_en_s;
    logic                    last_byte_s;
    logic                    word_valid_s;
    logic [31:0]             word_s;
    logic [15:0]             len_full_s;

    assign len_full_s = {in_data, len_lo_q};
    assign sync_s     = (in_data == SYNC_BYTE);

    boot_word_assembler u_asm (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (asm_clear_s),
        .byte_en_i    (asm_en_s),
        .byte_i       (in_data),
        .last_byte_o  (last_byte_s),
        .word_valid_o (word_valid_s),
        .word_o       (word_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; load_start overrides any accepted byte.
    always_comb begin
        state_d = state_q;
        if (load_start) begin
            state_d = ST_IDLE;
        end else if (accept_s) begin
            case (state_q)
                ST_IDLE: state_d = sync_s ? ST_LEN0 : ST_IDLE;
                ST_LEN0: state_d = ST_LEN1;
                ST_LEN1: begin
                    if ({1'b0, len_full_s} > IMEM_WORDS) begin
                        state_d = ST_ERROR;
                    end else if (len_full_s == 16'd0) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (last_byte_s && ((words_q + 16'd1) == len_q)) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_CSUM: state_d = (in_data == acc_q) ? ST_DONE : ST_ERROR;
                default: state_d = state_q;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // FSM outputs: handshake, assembler control and next values of status flags.
    always_comb begin
        in_ready_s   = !load_start && (state_q != ST_DONE) && (state_q != ST_ERROR);
        accept_s     = in_valid && in_ready_s;
        asm_en_s     = accept_s && (state_q == ST_DATA);
        asm_clear_s  = load_start || (accept_s && (state_q == ST_IDLE) && sync_s);
        core_rst_n_d = (state_q == ST_DONE) && !load_start;
        busy_d       = state_is_busy(state_d);
        done_d       = (state_d == ST_DONE);
        error_d      = (state_d == ST_ERROR);
    end

    // Datapath next state: length capture, word counter, checksum, write address.
    always_comb begin
        len_lo_d = len_lo_q;
        len_d    = len_q;
        words_d  = words_q;
        acc_d    = acc_q;
        waddr_d  = waddr_q;
        if (load_start) begin
            acc_d = {CSUM_WIDTH{1'b0}};
        end else if (accept_s) begin
            case (state_q)
                ST_IDLE: begin
                    if (sync_s) begin
                        words_d = 16'd0;
                        acc_d   = {CSUM_WIDTH{1'b0}};
                    end else begin
                        words_d = words_q;
                    end
                end
                ST_LEN0: len_lo_d = in_data;
                ST_LEN1: len_d    = len_full_s;
                ST_DATA: begin
                    acc_d = csum_update(acc_q, in_data);
                    if (last_byte_s) begin
                        words_d = words_q + 16'd1;
                        waddr_d = words_q[ADDR_WIDTH-1:0];
                    end else begin
                        words_d = words_q;
                    end
                end
                default: acc_d = acc_q;
            endcase
        end else begin
            acc_d = acc_q;
        end
    end

    // Datapath and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_lo_q     <= 8'd0;
            len_q        <= 16'd0;
            words_q      <= 16'd0;
            acc_q        <= {CSUM_WIDTH{1'b0}};
            waddr_q      <= {ADDR_WIDTH{1'b0}};
            core_rst_n_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            len_lo_q     <= len_lo_d;
            len_q        <= len_d;
            words_q      <= words_d;
            acc_q        <= acc_d;
            waddr_q      <= waddr_d;
            core_rst_n_q <= core_rst_n_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign in_ready     = in_ready_s;
    assign imem_we      = word_valid_s;
    assign imem_waddr   = waddr_q;
    assign imem_wdata   = word_s;
    assign core_rst_n   = core_rst_n_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed self-checking bench for imem_boot_loader: framing, checksum,
// length bounds, abort via load_start and asynchronous reset mid-load.
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [9:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic        core_rst_n;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    imem_boot_loader #(.ADDR_WIDTH(10), .SYNC_BYTE(8'hA5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_start   (load_start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .imem_we      (imem_we),
        .imem_waddr   (imem_waddr),
        .imem_wdata   (imem_wdata),
        .core_rst_n   (core_rst_n),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          we_count = 0;
    int          base;
    logic [9:0]  wa [0:2047];
    logic [31:0] wd [0:2047];
    logic [7:0]  bq [$];

    // Write-port monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (we_count < 2048) begin
                wa[we_count] = imem_waddr;
                wd[we_count] = imem_wdata;
            end
            we_count++;
        end
    end

    task automatic send_bytes();
        foreach (bq[i]) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = bq[i];
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'h00;
        #1;
    endtask

    task automatic pulse_load_start();
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; load_start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        #12;
        n_checks++;
        if ({imem_we, imem_waddr, imem_wdata, core_rst_n, busy, done, error, words_loaded} !== 62'd0)
            $display("FAIL reset_outputs: got we=%0b addr=%0h data=%0h crst=%0b busy=%0b done=%0b err=%0b words=%0d, want all 0",
                     imem_we, imem_waddr, imem_wdata, core_rst_n, busy, done, error, words_loaded);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_basic_load();
        base = we_count;
        // checksum 8'h90 = 13^93^10 over the data bytes
        bq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
        send_bytes();
        n_checks++;
        if (we_count - base !== 2) $display("FAIL load_we_count: got %0d want 2", we_count - base); else n_pass++;
        n_checks++;
        if (wa[base] !== 10'd0 || wd[base] !== 32'h00000013)
            $display("FAIL load_word0: got addr=%0d data=%h want addr=0 data=00000013", wa[base], wd[base]);
        else n_pass++;
        n_checks++;
        if (wa[base+1] !== 10'd1 || wd[base+1] !== 32'h00100093)
            $display("FAIL load_word1: got addr=%0d data=%h want addr=1 data=00100093", wa[base+1], wd[base+1]);
        else n_pass++;
        n_checks++;
        if (done !== 1'b1 || core_rst_n !== 1'b0 || words_loaded !== 16'd2 || in_ready !== 1'b0)
            $display("FAIL load_enter_done: got done=%0b crst=%0b words=%0d rdy=%0b want 1 0 2 0",
                     done, core_rst_n, words_loaded, in_ready);
        else n_pass++;
        @(negedge clk); #1;
        n_checks++;
        if (core_rst_n !== 1'b1 || done !== 1'b1)
            $display("FAIL load_core_release: got crst=%0b done=%0b want 1 1", core_rst_n, done);
        else n_pass++;
    endtask

    task automatic test_bad_checksum();
        pulse_load_start();
        n_checks++;
        if (core_rst_n !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || words_loaded !== 16'd2)
            $display("FAIL start_state: got crst=%0b done=%0b busy=%0b words=%0d want 0 0 0 2",
                     core_rst_n, done, busy, words_loaded);
        else n_pass++;
        base = we_count;
        bq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h81};
        send_bytes();
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (error !== 1'b1 || done !== 1'b0 || core_rst_n !== 1'b0 || in_ready !== 1'b0 || we_count - base !== 2)
            $display("FAIL bad_csum: got err=%0b done=%0b crst=%0b rdy=%0b writes=%0d want 1 0 0 0 2",
                     error, done, core_rst_n, in_ready, we_count - base);
        else n_pass++;
        pulse_load_start();
        bq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
        send_bytes();
        n_checks++;
        if (done !== 1'b1 || error !== 1'b0) $display("FAIL reload_done: got done=%0b err=%0b want 1 0", done, error);
        else n_pass++;
    endtask

    task automatic test_garbage_empty();
        pulse_load_start();
        base = we_count;
        bq = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00};
        send_bytes();
        n_checks++;
        if (done !== 1'b1 || we_count - base !== 0 || words_loaded !== 16'd0)
            $display("FAIL empty_frame: got done=%0b writes=%0d words=%0d want 1 0 0", done, we_count - base, words_loaded);
        else n_pass++;
    endtask

    task automatic test_len_overflow();
        pulse_load_start();
        base = we_count;
        bq = '{8'hA5, 8'h01, 8'h04};
        send_bytes();
        n_checks++;
        if (error !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0 || we_count - base !== 0)
            $display("FAIL len_overflow: got err=%0b busy=%0b rdy=%0b writes=%0d want 1 0 0 0",
                     error, busy, in_ready, we_count - base);
        else n_pass++;
    endtask

    task automatic test_full_capacity();
        logic [7:0]  cs;
        logic [31:0] w;
        pulse_load_start();
        base = we_count;
        cs = 8'h00;
        bq = '{8'hA5, 8'h00, 8'h04};
        for (int i = 0; i < 1024; i++) begin
            w = 32'h5A000000 | 32'(i * 3);
            for (int b = 0; b < 4; b++) begin
                bq.push_back(w[8*b +: 8]);
                cs = cs ^ w[8*b +: 8];
            end
        end
        bq.push_back(cs);
        send_bytes();
        n_checks++;
        if (done !== 1'b1 || words_loaded !== 16'd1024 || we_count - base !== 1024)
            $display("FAIL full_load: got done=%0b words=%0d writes=%0d want 1 1024 1024",
                     done, words_loaded, we_count - base);
        else n_pass++;
        n_checks++;
        if (wa[base+1023] !== 10'd1023 || wd[base+1023] !== 32'h5A000BFD)
            $display("FAIL full_last_word: got addr=%0d data=%h want addr=1023 data=5a000bfd",
                     wa[base+1023], wd[base+1023]);
        else n_pass++;
    endtask

    task automatic test_abort();
        pulse_load_start();
        base = we_count;
        bq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00};
        send_bytes();
        @(negedge clk);
        load_start = 1'b1; in_valid = 1'b1; in_data = 8'h00;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL abort_in_ready: got %0b want 0", in_ready); else n_pass++;
        @(negedge clk);
        load_start = 1'b0; in_valid = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || core_rst_n !== 1'b0 || we_count - base !== 0 || in_ready !== 1'b1)
            $display("FAIL abort_state: got busy=%0b crst=%0b writes=%0d rdy=%0b want 0 0 0 1",
                     busy, core_rst_n, we_count - base, in_ready);
        else n_pass++;
        bq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
        send_bytes();
        n_checks++;
        if (done !== 1'b1 || wa[base] !== 10'd0 || wd[base] !== 32'h00000013)
            $display("FAIL abort_reload: got done=%0b addr=%0d data=%h want 1 0 00000013", done, wa[base], wd[base]);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        pulse_load_start();
        base = we_count;
        bq = '{8'hA5, 8'h04, 8'h00};
        for (int i = 1; i <= 12; i++) bq.push_back(8'(i));
        send_bytes();
        n_checks++;
        if (we_count - base !== 3 || wd[base+2] !== 32'h0C0B0A09 || busy !== 1'b1)
            $display("FAIL pre_reset_words: got writes=%0d data=%h busy=%0b want 3 0c0b0a09 1",
                     we_count - base, wd[base+2], busy);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({imem_we, imem_waddr, imem_wdata, core_rst_n, busy, done, error, words_loaded} !== 62'd0)
            $display("FAIL async_reset: got we=%0b addr=%0h data=%0h crst=%0b busy=%0b words=%0d want all 0",
                     imem_we, imem_waddr, imem_wdata, core_rst_n, busy, words_loaded);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        base = we_count;
        bq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
        send_bytes();
        @(negedge clk); #1;
        n_checks++;
        if (done !== 1'b1 || core_rst_n !== 1'b1 || we_count - base !== 2 || wd[base+1] !== 32'h00100093)
            $display("FAIL post_reset_load: got done=%0b crst=%0b writes=%0d data=%h want 1 1 2 00100093",
                     done, core_rst_n, we_count - base, wd[base+1]);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_bad_checksum();
        test_garbage_empty();
        test_len_overflow();
        test_full_capacity();
        test_abort();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
